// File: rtl/acoustics_pkg.sv
// Shared types and sample conversion for the acoustics front end.
package acoustics_pkg;
  localparam int ADC_BITS = 10;
  localparam int SAMPLE_W = 16;
  localparam int AXIS_W   = 32;
  localparam int NUM_CH   = 2;

  typedef enum logic [1:0] {IDLE, CONV, GAP} rx_state_e;

  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } beat_t;

  // Offset-binary to two's complement: subtracting mid-scale is an MSB flip.
  function automatic logic [SAMPLE_W-1:0] to_signed_sample(input logic [ADC_BITS-1:0] code);
    logic [ADC_BITS-1:0] off;
    off = code ^ {1'b1, {(ADC_BITS-1){1'b0}}};
    return {{(SAMPLE_W-ADC_BITS){off[ADC_BITS-1]}}, off};
  endfunction
endpackage

// File: rtl/adc_serial_rx.sv
// SCLK/CS generator and per-channel serial shift-in for the dual ADC front end.
module adc_serial_rx
  import acoustics_pkg::*;
#(
  parameter int unsigned SCLK_DIV    = 7,
  parameter int unsigned CONV_SCLKS  = 16,
  parameter int unsigned LEAD_BITS   = 5,
  parameter int unsigned DATA_BITS   = 10,
  parameter int unsigned CS_HIGH_CYC = 40
) (
  input  logic                               clk,
  input  logic                               reset_b,
  input  logic                               enable_i,
  input  logic [NUM_CH-1:0]                  sdata_i,
  output logic                               sclk_o,
  output logic                               cs_b_o,
  output logic                               sample_valid_o,
  output logic [NUM_CH-1:0][DATA_BITS-1:0]   code_o
);
  localparam int DIV_W  = $clog2(SCLK_DIV);
  localparam int EDGE_W = $clog2(CONV_SCLKS + 1);
  localparam int GAP_W  = $clog2(CS_HIGH_CYC + 1);

  rx_state_e                       state_q, state_d;
  logic [DIV_W-1:0]                div_q, div_d;
  logic [EDGE_W-1:0]               fall_q, fall_d;
  logic [GAP_W-1:0]                gap_q, gap_d;
  logic                            sclk_q, sclk_d;
  logic                            tick, shift_en, data_done, valid_q;
  logic [NUM_CH-1:0]               meta_q, sync_q;
  logic [NUM_CH-1:0][DATA_BITS-1:0] shreg_q;

  assign tick = (div_q == DIV_W'(SCLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    fall_d    = fall_q;
    gap_d     = gap_q;
    sclk_d    = sclk_q;
    shift_en  = 1'b0;
    data_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = CONV;
          div_d   = '0;
          fall_d  = '0;
        end
      end
      CONV: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          // sclk_q high at a tick means this tick is a falling edge.
          if (sclk_q) begin
            fall_d = fall_q + 1'b1;
            if (fall_d >= EDGE_W'(LEAD_BITS) && fall_d <= EDGE_W'(LEAD_BITS + DATA_BITS - 1))
              shift_en = 1'b1;
            if (fall_d == EDGE_W'(LEAD_BITS + DATA_BITS - 1))
              data_done = 1'b1;
            if (fall_d == EDGE_W'(CONV_SCLKS)) begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(CS_HIGH_CYC - 1)) begin
          gap_d   = '0;
          div_d   = '0;
          fall_d  = '0;
          state_d = enable_i ? CONV : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      div_q   <= '0;
      fall_q  <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      meta_q  <= '0;
      sync_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      fall_q  <= fall_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      valid_q <= data_done;
      meta_q  <= sdata_i;
      sync_q  <= meta_q;
      if (shift_en)
        for (int l = 0; l < NUM_CH; l++)
          shreg_q[l] <= {shreg_q[l][DATA_BITS-2:0], sync_q[l]};
    end
  end

  assign sclk_o         = sclk_q;
  assign cs_b_o         = (state_q != CONV);
  assign sample_valid_o = valid_q;
  assign code_o         = shreg_q;
endmodule

// File: rtl/dual_adc_stream.sv
// Dual ADC to AXI-stream: sample conversion, tlast framing, output FIFO, overflow flag.
// Define DUAL_ADC_TEST_PATTERN_EN to replace ADC data with an internal ramp (r / ~r).
module dual_adc_stream
  import acoustics_pkg::*;
#(
  parameter int unsigned SCLK_DIV    = 7,
  parameter int unsigned CONV_SCLKS  = 16,
  parameter int unsigned LEAD_BITS   = 5,
  parameter int unsigned DATA_BITS   = ADC_BITS,
  parameter int unsigned CS_HIGH_CYC = 40,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic              clear_ovf,
  input  logic              adc1,
  input  logic              adc2,
  output logic              sclk,
  output logic              cs_b,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [AXIS_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic                              rx_valid;
  logic [NUM_CH-1:0][DATA_BITS-1:0]  rx_code, code;

  adc_serial_rx #(
    .SCLK_DIV    (SCLK_DIV),
    .CONV_SCLKS  (CONV_SCLKS),
    .LEAD_BITS   (LEAD_BITS),
    .DATA_BITS   (DATA_BITS),
    .CS_HIGH_CYC (CS_HIGH_CYC)
  ) u_rx (
    .clk            (clk),
    .reset_b        (reset_b),
    .enable_i       (enable),
    .sdata_i        ({adc2, adc1}),
    .sclk_o         (sclk),
    .cs_b_o         (cs_b),
    .sample_valid_o (rx_valid),
    .code_o         (rx_code)
  );

`ifdef DUAL_ADC_TEST_PATTERN_EN
  logic [DATA_BITS-1:0] ramp_q;
  // Ramp advances on every push attempt, including dropped ones.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)      ramp_q <= '0;
    else if (rx_valid) ramp_q <= ramp_q + 1'b1;
  end
  assign code = {~ramp_q, ramp_q};
`else
  assign code = rx_code;
`endif

  beat_t               mem_q [FIFO_DEPTH];
  beat_t               wr_beat;
  logic [AW-1:0]       rd_q, wr_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       beat_q;
  logic                ovf_q, full, pop, accept, drop;

  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign pop    = m_tvalid && m_tready;
  assign accept = rx_valid && (!full || pop);
  assign drop   = rx_valid && full && !pop;

  assign wr_beat.data = {to_signed_sample(code[1]), to_signed_sample(code[0])};
  assign wr_beat.last = (beat_q == BW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= wr_beat;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(accept) - CW'(pop);
    end
  end

  // Frame position follows accepted pairs only; drops leave it untouched.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      beat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) beat_q <= wr_beat.last ? '0 : beat_q + 1'b1;
      if (drop)           ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

  assign m_tvalid = (cnt_q != '0);
  assign m_tdata  = mem_q[rd_q].data;
  assign m_tlast  = mem_q[rd_q].last;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_dual_adc_stream.sv
// Directed bench for dual_adc_stream with a serial ADC model driven off sclk/cs_b.
module tb_dual_adc_stream;
  localparam int FRAME = 4;

  logic        clk = 1'b0;
  logic        reset_b, enable, clear_ovf, m_tready;
  logic        adc1 = 1'b0, adc2 = 1'b0;
  logic        sclk, cs_b, m_tvalid, m_tlast, ovf;
  logic [31:0] m_tdata;

  int checks = 0;
  int errors = 0;

  logic [9:0]  q1[$], q2[$];
  logic [9:0]  cur1, cur2;
  int          edge_n;
  bit          in_conv = 1'b0;
  logic [31:0] got_d[$];
  logic        got_l[$];

  always #5 clk = ~clk;

  dual_adc_stream #(
    .SCLK_DIV(7), .CONV_SCLKS(16), .LEAD_BITS(5), .DATA_BITS(10),
    .CS_HIGH_CYC(40), .FRAME_LEN(FRAME), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .clear_ovf(clear_ovf),
    .adc1(adc1), .adc2(adc2), .sclk(sclk), .cs_b(cs_b),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .ovf(ovf)
  );

  function automatic logic bit_for(input logic [9:0] c, input int k);
    if (k >= 5 && k <= 14) return c[14-k];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [9:0] c1, input logic [9:0] c2);
    int s1, s2;
    s1 = int'(c1) - 512;
    s2 = int'(c2) - 512;
    return {s2[15:0], s1[15:0]};
  endfunction

  // ADC model: the bit for falling edge k is presented right after falling edge k-1.
  always @(negedge cs_b or posedge cs_b or negedge sclk) begin
    if (cs_b !== 1'b0) in_conv = 1'b0;
    else if (!in_conv) begin
      in_conv = 1'b1;
      edge_n  = 0;
      if (q1.size() != 0) cur1 = q1.pop_front(); else cur1 = 10'h155;
      if (q2.size() != 0) cur2 = q2.pop_front(); else cur2 = 10'h2AA;
      adc1 = bit_for(cur1, 1);
      adc2 = bit_for(cur2, 1);
    end else begin
      edge_n++;
      adc1 = bit_for(cur1, edge_n + 1);
      adc2 = bit_for(cur2, edge_n + 1);
    end
  end

  always @(negedge clk)
    if (reset_b === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      got_d.push_back(m_tdata);
      got_l.push_back(m_tlast);
    end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_b = 1'b0; enable = 1'b0; m_tready = 1'b0; clear_ovf = 1'b0;
    got_d.delete(); got_l.delete(); q1.delete(); q2.delete();
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
  endtask

  task automatic wait_cs_fall(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = cs_b;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && cs_b === 1'b0) begin ok = 1'b1; break; end
      prev = cs_b;
    end
  endtask

  task automatic run_convs(input int n);
    bit ok;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_cs_fall(ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL cs_fall_timeout: conversion %0d did not start", i);
        break;
      end
    end
    #1 enable = 1'b0;
    for (int c = 0; c < 300 && cs_b !== 1'b1; c++) @(negedge clk);
    if (cs_b !== 1'b1) begin
      checks++; errors++;
      $display("FAIL conv_end_timeout: cs_b=%b want 1", cs_b);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (got_d.size() < n && c < 3000) begin @(negedge clk); c++; end
    if (got_d.size() < n) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats want %0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b0)       begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (cs_b !== 1'b1)       begin errors++; $display("FAIL reset_cs_b: got %b want 1", cs_b); end
    checks++; if (m_tvalid !== 1'b0)   begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0)    begin errors++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    checks++; if (m_tdata !== 32'h0)   begin errors++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    @(posedge clk); #1 reset_b = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int low;
    do_reset();
    m_tready = 1'b1;
    q1.push_back(10'h3FF); q2.push_back(10'h000);
    enable = 1'b1;
    wait_cs_fall(ok);
    #1 enable = 1'b0;
    low = ok ? 1 : 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cs_b === 1'b0) low++; else break;
    end
    checks++; if (low != 224) begin errors++; $display("FAIL cs_low_width: got %0d cycles want 224", low); end
    wait_beats(1);
    checks++; if (got_d[0] !== 32'hFE00_01FF) begin errors++; $display("FAIL basic_data: got %h want fe0001ff", got_d[0]); end
    checks++; if (got_l[0] !== 1'b0) begin errors++; $display("FAIL basic_last: got %b want 0", got_l[0]); end
  endtask

  task automatic test_frame();
    logic [9:0] e1[10], e2[10];
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e1[i] = 10'(64 + 37 * i);
      e2[i] = 10'(960 - 91 * i);
      q1.push_back(e1[i]); q2.push_back(e2[i]);
    end
    run_convs(10);
    wait_beats(10);
    repeat (20) @(negedge clk);
    checks++; if (got_d.size() != 10) begin errors++; $display("FAIL frame_count: got %0d want 10", got_d.size()); end
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_beat(e1[i], e2[i])) begin
        errors++; $display("FAIL frame_data[%0d]: got %h want %h", i, got_d[i], exp_beat(e1[i], e2[i]));
      end
      checks++;
      if (got_l[i] !== ((i == 3) || (i == 7))) begin
        errors++; $display("FAIL frame_last[%0d]: got %b want %b", i, got_l[i], (i == 3) || (i == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] e1[6], e2[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      e1[i] = 10'(100 + 150 * i);
      e2[i] = 10'(900 - 130 * i);
      q1.push_back(e1[i]); q2.push_back(e2[i]);
    end
    run_convs(6);
    repeat (10) @(negedge clk);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_held: got %b want 1", m_tvalid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %b want 1", ovf); end
    checks++; if (m_tdata !== exp_beat(e1[0], e2[0])) begin errors++; $display("FAIL bp_head_stable: got %h want %h", m_tdata, exp_beat(e1[0], e2[0])); end
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL bp_no_transfer: got %0d beats want 0", got_d.size()); end
    @(posedge clk); #1 m_tready = 1'b1;
    wait_beats(4);
    repeat (20) @(negedge clk);
    checks++; if (got_d.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got_d.size()); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", m_tvalid); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_beat(e1[i], e2[i])) begin
        errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_d[i], exp_beat(e1[i], e2[i]));
      end
      checks++;
      if (got_l[i] !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", i, got_l[i], i == 3); end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", ovf); end
    @(posedge clk); #1 clear_ovf = 1'b1;
    @(posedge clk); #1 clear_ovf = 1'b0;
    @(negedge clk);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_reset_midconv();
    bit ok;
    logic prev;
    int falls = 0;
    do_reset();
    m_tready = 1'b1;
    enable = 1'b1;
    wait_cs_fall(ok);
    prev = sclk;
    for (int c = 0; c < 300 && falls < 8; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && sclk === 1'b0) falls++;
      prev = sclk;
    end
    reset_b = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if (falls != 8) begin errors++; $display("FAIL mid_falls: got %0d want 8", falls); end
    checks++; if (cs_b !== 1'b1) begin errors++; $display("FAIL mid_cs_b: got %b want 1", cs_b); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b want 0", sclk); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_tvalid); end
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    q1.push_back(10'h2C7); q2.push_back(10'h0F3);
    run_convs(1);
    wait_beats(1);
    repeat (20) @(negedge clk);
    checks++; if (got_d.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_d.size()); end
    checks++; if (got_d[0] !== exp_beat(10'h2C7, 10'h0F3)) begin errors++; $display("FAIL mid_data: got %h want %h", got_d[0], exp_beat(10'h2C7, 10'h0F3)); end
    checks++; if (got_l[0] !== 1'b0) begin errors++; $display("FAIL mid_last: got %b want 0", got_l[0]); end
  endtask

  task automatic test_enable_drop();
    logic [9:0] e1[5], e2[5];
    int low = 0;
    bit any_last = 1'b0;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e1[i] = 10'(500 + 61 * i);
      e2[i] = 10'(20 + 177 * i);
      q1.push_back(e1[i]); q2.push_back(e2[i]);
    end
    run_convs(3);
    wait_beats(3);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cs_b !== 1'b1) low++;
    end
    checks++; if (low != 0) begin errors++; $display("FAIL en_idle_cs: got %0d low cycles want 0", low); end
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL en_count3: got %0d want 3", got_d.size()); end
    for (int i = 0; i < got_l.size(); i++) any_last |= got_l[i];
    checks++; if (any_last !== 1'b0) begin errors++; $display("FAIL en_early_last: got %b want 0", any_last); end
    run_convs(2);
    wait_beats(5);
    repeat (20) @(negedge clk);
    checks++; if (got_d.size() != 5) begin errors++; $display("FAIL en_count5: got %0d want 5", got_d.size()); end
    checks++; if (got_l[3] !== 1'b1) begin errors++; $display("FAIL en_last4: got %b want 1", got_l[3]); end
    checks++; if (got_l[4] !== 1'b0) begin errors++; $display("FAIL en_last5: got %b want 0", got_l[4]); end
    checks++; if (got_d[2] !== exp_beat(e1[2], e2[2])) begin errors++; $display("FAIL en_data3: got %h want %h", got_d[2], exp_beat(e1[2], e2[2])); end
    checks++; if (got_d[4] !== exp_beat(e1[4], e2[4])) begin errors++; $display("FAIL en_data5: got %h want %h", got_d[4], exp_beat(e1[4], e2[4])); end
  endtask

`ifdef DUAL_ADC_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [9:0] r;
    do_reset();
    m_tready = 1'b1;
    run_convs(5);
    wait_beats(5);
    for (int n = 0; n < 5 && n < got_d.size(); n++) begin
      r = 10'(n);
      checks++;
      if (got_d[n] !== exp_beat(r, ~r)) begin
        errors++; $display("FAIL pattern[%0d]: got %h want %h", n, got_d[n], exp_beat(r, ~r));
      end
    end
  endtask
`endif

  initial begin
    reset_b = 1'b0; enable = 1'b0; clear_ovf = 1'b0; m_tready = 1'b0;
    test_reset();
`ifdef DUAL_ADC_TEST_PATTERN_EN
    test_pattern();
`else
    test_basic();
    test_frame();
    test_backpressure();
    test_reset_midconv();
    test_enable_drop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
